// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with run control.
// Detects a 1..MAX_LEN bit pattern on a valid-qualified serial stream,
// with optional overlap. It counts matches and stops in DONE when a
// non-zero target count is reached.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   cfg_*           config handshake (accepted in IDLE/DONE only)
//   start, abort    run control
//   x, x_valid      serial bit and its qualifier
//   y               registered one-cycle match pulse
//   busy, done      RUN / DONE state flags
//   match_count     matches in the current or last run (saturating)
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [$clog2(MAX_LEN):0]  cfg_len,
  input  logic                      cfg_overlap,
  input  logic [CNT_W-1:0]          cfg_target,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      x,
  input  logic                      x_valid,
  output logic                      y,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          match_count
);

  localparam int LW = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LW-1:0]      fill_q;
  logic               y_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cfg_take;
  logic [LW-1:0]      len_in;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_d;
  logic [LW-1:0]      fill_inc;
  logic               match;
  logic [CNT_W-1:0]   cnt_inc;
  logic               tgt_hit;

  assign cfg_take = cfg_valid && (state_q != RUN);

  // Out-of-range lengths are clamped into 1..MAX_LEN on acceptance.
  always_comb begin
    len_in = cfg_len;
    if (cfg_len == '0)
      len_in = LW'(1);
    else if (cfg_len > LW'(MAX_LEN))
      len_in = LW'(MAX_LEN);
  end

  // Next-state logic, including the match evaluation on the shifted history.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      mask[i] = (i < 32'(len_q));
    hist_d   = {hist_q[MAX_LEN-2:0], x};
    fill_inc = (fill_q == len_q) ? len_q : fill_q + LW'(1);
    match    = (fill_inc == len_q) && ((hist_d & mask) == (pat_q & mask));
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    tgt_hit  = match && (tgt_q != '0) && (cnt_inc == tgt_q);

    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !abort) state_d = RUN;
      RUN: begin
        if (abort)                   state_d = IDLE;
        else if (x_valid && tgt_hit) state_d = DONE;
      end
      DONE: begin
        if (abort)      state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q  <= MAX_LEN'(7);
      len_q  <= LW'(3);
      ovl_q  <= 1'b1;
      tgt_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (cfg_take) begin
        pat_q <= cfg_pattern;
        len_q <= len_in;
        ovl_q <= cfg_overlap;
        tgt_q <= cfg_target;
      end
      // y is a one-cycle pulse; only a match below re-asserts it.
      y_q <= 1'b0;
      if (state_q != RUN) begin
        if (start && !abort) begin
          hist_q <= '0;
          fill_q <= '0;
          cnt_q  <= '0;
        end
      end else if (!abort && x_valid) begin
        hist_q <= hist_d;
        // Non-overlap restarts the fill so the next match needs len fresh bits.
        fill_q <= (match && !ovl_q) ? '0 : fill_inc;
        if (match) begin
          y_q   <= 1'b1;
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    cfg_ready = (state_q != RUN);
  end

  assign y           = y_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic       x;
  logic       x_valid;
  logic       y;
  logic       busy;
  logic       done;
  logic [7:0] match_count;

  int checks = 0;
  int errors = 0;

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .x(x), .x_valid(x_valid),
    .y(y), .busy(busy), .done(done), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n valid bits (bits[0] first) and checks y after each edge.
  task automatic run_bits(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] ey);
    for (int i = 0; i < n; i++) begin
      x = bits[i];
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      check($sformatf("%s_y%0d", tag, i), y, ey[i]);
    end
  endtask

  task automatic cfg_start(input logic [7:0] p, input logic [3:0] l,
                           input logic o, input logic [7:0] t);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", match_count, 0);
    check("rst_cfg_ready", cfg_ready, 1);

    // 1: default 111 overlapping
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_cfg_ready", cfg_ready, 0);
    run_bits("t1", 6, 16'b111111, 16'b111100);
    check("t1_cnt", match_count, 4);
    check("t1_busy_end", busy, 1);
    do_abort();
    check("t1_abort_busy", busy, 0);
    check("t1_abort_cnt", match_count, 4);

    // 2: non-overlap
    cfg_start(8'b111, 4'd3, 1'b0, 8'd0);
    check("t2_cnt0", match_count, 0);
    run_bits("t2", 6, 16'b111111, 16'b100100);
    check("t2_cnt", match_count, 2);
    do_abort();

    // 3: 1011 with target 2
    cfg_start(8'b1011, 4'd4, 1'b1, 8'd2);
    run_bits("t3", 7, 16'b1101101, 16'b1001000);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_cnt", match_count, 2);
    check("t3_cfg_ready", cfg_ready, 1);
    run_bits("t3_after", 4, 16'b1101, 16'b0000);
    check("t3_cnt_after", match_count, 2);

    // 4: bubbles, and config offered while running is refused
    cfg_start(8'b111, 4'd3, 1'b1, 8'd0);
    check("t4_done_clr", done, 0);
    check("t4_busy", busy, 1);
    run_bits("t4_pre", 2, 16'b11, 16'b00);
    cfg_valid = 1'b1; cfg_pattern = 8'b0; cfg_len = 4'd3;
    for (int i = 0; i < 3; i++) begin
      x = 1'b1; x_valid = 1'b0;
      tick();
      check($sformatf("t4_bubble_y%0d", i), y, 0);
      check($sformatf("t4_cfg_ready%0d", i), cfg_ready, 0);
    end
    run_bits("t4_bit3", 1, 16'b1, 16'b1);
    cfg_valid = 1'b0;
    check("t4_cnt", match_count, 1);

    // 5: abort+start together with a completing bit
    x = 1'b1; x_valid = 1'b1; abort = 1'b1; start = 1'b1;
    tick();
    x_valid = 1'b0; abort = 1'b0; start = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_y", y, 0);
    check("t5_cnt", match_count, 1);
    tick();
    check("t5_idle_hold", busy, 0);

    // 6: mid-run reset restores default config
    cfg_start(8'b00, 4'd2, 1'b0, 8'd5);
    run_bits("t6_pre", 2, 16'b11, 16'b00);
    x = 1'b1; x_valid = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1; x_valid = 1'b0;
    check("t6_rst_y", y, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_cnt", match_count, 0);
    check("t6_rst_cfg_ready", cfg_ready, 1);
    start = 1'b1; tick(); start = 1'b0;
    run_bits("t6", 3, 16'b111, 16'b100);
    check("t6_cnt", match_count, 1);
    do_abort();

    // 7: len=0 clamps to 1
    cfg_start(8'b1, 4'd0, 1'b1, 8'd0);
    run_bits("t7", 4, 16'b1011, 16'b1011);
    check("t7_cnt", match_count, 3);
    do_abort();

    // len above MAX_LEN clamps to MAX_LEN
    cfg_start(8'hFF, 4'd15, 1'b1, 8'd0);
    run_bits("t8", 9, 16'b111111111, 16'b110000000);
    check("t8_cnt", match_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
